// File: rtl/board_renderer.sv
// Board renderer: turns the display driver's pixel requests into RGB565 pixels of an
// N x N game board with grid lines, a cursor outline and a blinking winning line.
module board_renderer #(
    parameter int H_RES      = 800,
    parameter int V_RES      = 480,
    parameter int GRID_N     = 3,
    parameter int LINE_W     = 1,
    parameter int CUR_W      = 3,
    parameter int BLINK_LOG2 = 5
) (
    input  logic                         ClkDisp,
    input  logic                         Rst_p,
    input  logic                         DataReq,
    input  logic [11:0]                  H_Addr,
    input  logic [11:0]                  V_Addr,
    input  logic [2*GRID_N*GRID_N-1:0]   board,
    input  logic                         cursor_en,
    input  logic [5:0]                   cursor_idx,
    input  logic [GRID_N*GRID_N-1:0]     win_mask,
    output logic [15:0]                  Data,
    output logic                         Data_vld
);

    localparam int CELLS = GRID_N * GRID_N;
    localparam int CB    = $clog2(CELLS);
    localparam int CW    = H_RES / GRID_N;
    localparam int CH    = V_RES / GRID_N;
    localparam logic [11:0] LAST_W = 12'(H_RES - (GRID_N - 1) * CW);
    localparam logic [11:0] LAST_H = 12'(V_RES - (GRID_N - 1) * CH);

    localparam logic [15:0] BLACK  = 16'h0000;
    localparam logic [15:0] WHITE  = 16'hFFFF;
    localparam logic [15:0] RED    = 16'hF800;
    localparam logic [15:0] GREEN  = 16'h07E0;
    localparam logic [15:0] YELLOW = 16'hFFE0;
    localparam logic [15:0] BLUE   = 16'h001F;

    logic [3:0]             col_reg, col_next, row_reg, row_next;
    logic [11:0]            xoff_reg, xoff_next, yoff_reg, yoff_next;
    logic                   line_start, frame_end;

    logic [2*CELLS-1:0]     board_s;
    logic                   cursor_en_s;
    logic [5:0]             cursor_idx_s;
    logic [CELLS-1:0]       win_mask_s;
    logic [BLINK_LOG2:0]    frame_cnt;

    logic [1:0]             cell_state [CELLS];
    logic [CB-1:0]          cell_idx;
    logic [11:0]            cell_w, cell_h, x_lo, y_lo;
    logic                   on_grid, near_edge, cursor_hit, on_cursor, blink_on;
    logic [15:0]            color;

    logic                   vld_reg;
    logic [15:0]            color_reg;

    generate
        for (genvar gi = 0; gi < CELLS; gi++) begin : g_cell
            assign cell_state[gi] = board_s[2*gi +: 2];
        end
    endgenerate

    assign line_start = DataReq && (H_Addr == 12'd0);
    assign frame_end  = DataReq && (H_Addr == 12'(H_RES - 1)) && (V_Addr == 12'(V_RES - 1));

    // Position of the pixel being requested now; it also becomes the stored state.
    // The last column/row keeps counting past CW/CH so it absorbs the remainder.
    always_comb begin
        col_next  = col_reg;
        xoff_next = xoff_reg;
        if (H_Addr == 12'd0) begin
            col_next  = 4'd0;
            xoff_next = 12'd0;
        end else if (xoff_reg == 12'(CW - 1) && col_reg < 4'(GRID_N - 1)) begin
            col_next  = col_reg + 4'd1;
            xoff_next = 12'd0;
        end else begin
            xoff_next = xoff_reg + 12'd1;
        end

        row_next  = row_reg;
        yoff_next = yoff_reg;
        if (line_start) begin
            if (V_Addr == 12'd0) begin
                row_next  = 4'd0;
                yoff_next = 12'd0;
            end else if (yoff_reg == 12'(CH - 1) && row_reg < 4'(GRID_N - 1)) begin
                row_next  = row_reg + 4'd1;
                yoff_next = 12'd0;
            end else begin
                yoff_next = yoff_reg + 12'd1;
            end
        end
    end

    // Pixel classification and colour, using only the shadow copies of the inputs.
    always_comb begin
        cell_idx   = CB'(32'(row_next) * GRID_N + 32'(col_next));
        on_grid    = (xoff_next < 12'(LINE_W) && col_next != 4'd0) ||
                     (yoff_next < 12'(LINE_W) && row_next != 4'd0);
        x_lo       = (col_next != 4'd0) ? 12'(LINE_W + CUR_W) : 12'(CUR_W);
        y_lo       = (row_next != 4'd0) ? 12'(LINE_W + CUR_W) : 12'(CUR_W);
        cell_w     = (col_next == 4'(GRID_N - 1)) ? LAST_W : 12'(CW);
        cell_h     = (row_next == 4'(GRID_N - 1)) ? LAST_H : 12'(CH);
        near_edge  = (xoff_next < x_lo) || (xoff_next >= cell_w - 12'(CUR_W)) ||
                     (yoff_next < y_lo) || (yoff_next >= cell_h - 12'(CUR_W));
        cursor_hit = cursor_en_s && ({1'b0, cursor_idx_s} < 7'(CELLS)) &&
                     ({1'b0, cursor_idx_s} == 7'(cell_idx));
        on_cursor  = !on_grid && cursor_hit && near_edge;
        blink_on   = win_mask_s[cell_idx] && frame_cnt[BLINK_LOG2];

        if (on_grid)
            color = BLACK;
        else if (on_cursor)
            color = RED;
        else if (blink_on)
            color = GREEN;
        else begin
            case (cell_state[cell_idx])
                2'b01:   color = YELLOW;
                2'b10:   color = BLUE;
                default: color = WHITE;
            endcase
        end
    end

    always_ff @(posedge ClkDisp) begin
        if (Rst_p) begin
            col_reg      <= 4'd0;
            xoff_reg     <= 12'd0;
            row_reg      <= 4'd0;
            yoff_reg     <= 12'd0;
            board_s      <= '0;
            cursor_en_s  <= 1'b0;
            cursor_idx_s <= 6'd0;
            win_mask_s   <= '0;
            frame_cnt    <= '0;
            vld_reg      <= 1'b0;
            color_reg    <= BLACK;
            Data_vld     <= 1'b0;
            Data         <= BLACK;
        end else begin
            if (DataReq) begin
                col_reg  <= col_next;
                xoff_reg <= xoff_next;
            end
            row_reg   <= row_next;
            yoff_reg  <= yoff_next;
            vld_reg   <= DataReq;
            color_reg <= DataReq ? color : BLACK;
            Data_vld  <= vld_reg;
            Data      <= vld_reg ? color_reg : BLACK;
            // The last pixel of the frame was coloured with the old shadow above.
            if (frame_end) begin
                board_s      <= board;
                cursor_en_s  <= cursor_en;
                cursor_idx_s <= cursor_idx;
                win_mask_s   <= win_mask;
                frame_cnt    <= frame_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_board_renderer.sv
// Directed bench for board_renderer: expected pixels are queued when requested and
// compared when the renderer returns them, on a 3x3 default board and a 4x4 802-wide board.
module tb_board_renderer;

    localparam logic [15:0] BLACK  = 16'h0000;
    localparam logic [15:0] WHITE  = 16'hFFFF;
    localparam logic [15:0] RED    = 16'hF800;
    localparam logic [15:0] GREEN  = 16'h07E0;
    localparam logic [15:0] YELLOW = 16'hFFE0;
    localparam logic [15:0] BLUE   = 16'h001F;

    typedef struct {
        int          h;
        int          v;
        logic [15:0] e;
        string       tag;
    } cp_t;

    typedef struct {
        bit          chk;
        logic [15:0] e;
        string       tag;
        int          h;
        int          v;
    } sb_t;

    logic        clk = 1'b0;
    logic        rst, req_a, req_b;
    logic [11:0] h_addr, v_addr;
    logic [17:0] board_a;
    logic        cur_en_a;
    logic [5:0]  cur_idx_a;
    logic [8:0]  win_a;
    logic [31:0] board_b;
    logic        cur_en_b;
    logic [5:0]  cur_idx_b;
    logic [15:0] win_b;
    logic [15:0] data_a, data_b;
    logic        vld_a, vld_b;

    cp_t  cps[$];
    sb_t  sb_a[$];
    sb_t  sb_b[$];
    sb_t  ea, eb;
    int   sel, hres, vres;
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;
    logic ma1 = 1'b0, ma2 = 1'b0, mb1 = 1'b0, mb2 = 1'b0;

    always #5 clk = ~clk;

    board_renderer #(.BLINK_LOG2(1)) dut_a (
        .ClkDisp(clk), .Rst_p(rst), .DataReq(req_a), .H_Addr(h_addr), .V_Addr(v_addr),
        .board(board_a), .cursor_en(cur_en_a), .cursor_idx(cur_idx_a), .win_mask(win_a),
        .Data(data_a), .Data_vld(vld_a)
    );

    board_renderer #(.H_RES(802), .V_RES(40), .GRID_N(4)) dut_b (
        .ClkDisp(clk), .Rst_p(rst), .DataReq(req_b), .H_Addr(h_addr), .V_Addr(v_addr),
        .board(board_b), .cursor_en(cur_en_b), .cursor_idx(cur_idx_b), .win_mask(win_b),
        .Data(data_b), .Data_vld(vld_b)
    );

    // Output side: valid must follow requests by two cycles, Data is BLACK when idle.
    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            assert (vld_a === ma2) else begin errors++; $error("FAIL vld_a observed %b expected %b", vld_a, ma2); end
            if (vld_a === 1'b1) begin
                checks++;
                assert (sb_a.size() != 0) else begin errors++; $error("FAIL sb_a_underrun observed %0d expected >0", sb_a.size()); end
                if (sb_a.size() != 0) begin
                    ea = sb_a.pop_front();
                    if (ea.chk) begin
                        checks++;
                        $display("pix %s (%0d,%0d) data=%h", ea.tag, ea.h, ea.v, data_a);
                        assert (data_a === ea.e) else begin errors++; $error("FAIL %s observed %h expected %h", ea.tag, data_a, ea.e); end
                    end
                end
            end else begin
                checks++;
                assert (data_a === BLACK) else begin errors++; $error("FAIL idle_data_a observed %h expected %h", data_a, BLACK); end
            end

            checks++;
            assert (vld_b === mb2) else begin errors++; $error("FAIL vld_b observed %b expected %b", vld_b, mb2); end
            if (vld_b === 1'b1) begin
                checks++;
                assert (sb_b.size() != 0) else begin errors++; $error("FAIL sb_b_underrun observed %0d expected >0", sb_b.size()); end
                if (sb_b.size() != 0) begin
                    eb = sb_b.pop_front();
                    if (eb.chk) begin
                        checks++;
                        $display("pix %s (%0d,%0d) data=%h", eb.tag, eb.h, eb.v, data_b);
                        assert (data_b === eb.e) else begin errors++; $error("FAIL %s observed %h expected %h", eb.tag, data_b, eb.e); end
                    end
                end
            end else begin
                checks++;
                assert (data_b === BLACK) else begin errors++; $error("FAIL idle_data_b observed %h expected %h", data_b, BLACK); end
            end
        end
        ma2 = rst ? 1'b0 : ma1;
        ma1 = rst ? 1'b0 : req_a;
        mb2 = rst ? 1'b0 : mb1;
        mb1 = rst ? 1'b0 : req_b;
    end

    task automatic add(input int h, input int v, input logic [15:0] e, input string tag);
        cp_t c;
        c.h = h; c.v = v; c.e = e; c.tag = tag;
        cps.push_back(c);
    endtask

    task automatic add_blink(input bit green, input string pfx);
        logic [15:0] c;
        c = green ? GREEN : WHITE;
        add(100, 80, c, {pfx, "_win_c0"});
        add(400, 80, c, {pfx, "_win_c1"});
        add(700, 80, c, {pfx, "_win_c2"});
        add(100, 240, WHITE, {pfx, "_nowin_c3"});
    endtask

    task automatic pix(input int h, input int v);
        sb_t s;
        s.chk = 1'b0; s.e = BLACK; s.tag = ""; s.h = h; s.v = v;
        foreach (cps[i]) begin
            if (cps[i].h == h && cps[i].v == v) begin
                s.chk = 1'b1; s.e = cps[i].e; s.tag = cps[i].tag;
            end
        end
        h_addr = 12'(h);
        v_addr = 12'(v);
        if (sel == 0) begin
            req_a = 1'b1; req_b = 1'b0; sb_a.push_back(s);
        end else begin
            req_b = 1'b1; req_a = 1'b0; sb_b.push_back(s);
        end
        @(posedge clk); #1;
    endtask

    // Lines without checkpoints get only their first pixel, which still steps the row counter.
    task automatic run_lines(input int v0, input int v1);
        for (int v = v0; v <= v1; v++) begin
            bit full;
            full = (v == vres - 1);
            foreach (cps[i]) if (cps[i].v == v) full = 1'b1;
            if (full) begin
                for (int h = 0; h < hres; h++) pix(h, v);
            end else begin
                pix(0, v);
            end
        end
        req_a = 1'b0;
        req_b = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req_a = 1'b0; req_b = 1'b0; h_addr = 12'd0; v_addr = 12'd0;
        board_a = 18'h0; cur_en_a = 1'b0; cur_idx_a = 6'd0; win_a = 9'h007;
        board_b = 32'h0; cur_en_b = 1'b1; cur_idx_b = 6'd3; win_b = 16'h0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        mon_en = 1'b1;

        // 4x4 board, 802 wide: remainder column and cursor on cell 3
        sel = 1; hres = 802; vres = 40;
        add(601, 5, WHITE, "b_cursor_not_loaded");
        run_lines(0, 39); cps.delete();
        add(599, 5, WHITE, "b_x599_col2");
        add(600, 5, BLACK, "b_line_x600");
        add(601, 5, RED,   "b_x601_cursor_left");
        add(604, 5, WHITE, "b_x604_inside");
        add(798, 5, WHITE, "b_x798_inside_wide_col");
        add(799, 5, RED,   "b_x799_cursor_right");
        add(801, 5, RED,   "b_x801_in_col3");
        run_lines(0, 39); cps.delete();

        // default 3x3 board
        sel = 0; hres = 800; vres = 480;
        // frame 0: empty board; board input changes mid-frame
        add(266, 10, BLACK, "f0_vline_266");
        add(267, 10, WHITE, "f0_x267");
        add(10, 160, BLACK, "f0_hline_160");
        add(799, 479, WHITE, "f0_last_pixel");
        add(400, 240, WHITE, "f0_midframe_change_hidden");
        add_blink(1'b0, "f0");
        run_lines(0, 199);
        board_a = 18'h20100;
        run_lines(200, 479); cps.delete();

        // frame 1: new board visible, blink phase off
        add(400, 240, YELLOW, "f1_c4_yellow");
        add(700, 400, BLUE,   "f1_c8_blue");
        add_blink(1'b0, "f1");
        run_lines(0, 479); cps.delete();

        // frames 2-3: blink phase on
        add(400, 240, YELLOW, "f2_c4_yellow");
        add_blink(1'b1, "f2");
        run_lines(0, 479); cps.delete();
        add(400, 240, YELLOW, "f3_c4_yellow");
        add_blink(1'b1, "f3");
        run_lines(0, 239);
        cur_en_a = 1'b1; cur_idx_a = 6'd0;
        run_lines(240, 479); cps.delete();

        // frame 4: cursor on cell 0, blink off
        add(0, 0, RED, "f4_cursor_0_0");
        add(2, 100, RED, "f4_cursor_2_100");
        add(3, 100, WHITE, "f4_inside_3_100");
        add(400, 240, YELLOW, "f4_c4_yellow");
        add_blink(1'b0, "f4");
        run_lines(0, 199);
        cur_idx_a = 6'd9;
        run_lines(200, 479); cps.delete();

        // frame 5: cursor_idx out of range
        add(0, 0, WHITE, "f5_idx9_0_0");
        add(2, 100, WHITE, "f5_idx9_2_100");
        add_blink(1'b0, "f5");
        run_lines(0, 479); cps.delete();

        // frame 6: reset pulsed in the middle of line 51
        add(10, 51, GREEN, "f6_blink_c0");
        run_lines(0, 50);
        for (int h = 0; h <= 20; h++) pix(h, 51);
        req_a = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sb_a.delete();
        cps.delete();

        // frame after reset: shadows empty, counters resynchronised
        add(266, 10, BLACK, "r0_vline_266");
        add(267, 10, WHITE, "r0_x267");
        add(10, 160, BLACK, "r0_hline_160");
        add(0, 0, WHITE, "r0_no_cursor");
        add(100, 80, WHITE, "r0_no_win");
        add(400, 240, WHITE, "r0_board_cleared");
        add(799, 479, WHITE, "r0_last_pixel");
        run_lines(0, 479); cps.delete();

        add(400, 240, YELLOW, "r1_c4_yellow");
        add(700, 400, BLUE, "r1_c8_blue");
        add(0, 0, WHITE, "r1_idx9_0_0");
        run_lines(0, 479); cps.delete();

        repeat (5) @(posedge clk);
        #1;
        checks++;
        assert (sb_a.size() == 0) else begin errors++; $error("FAIL sb_a_drain observed %0d expected 0", sb_a.size()); end
        checks++;
        assert (sb_b.size() == 0) else begin errors++; $error("FAIL sb_b_drain observed %0d expected 0", sb_b.size()); end
        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
